// File: rtl/mandelbrot_frame_sched.sv
// Frame sequencer for the Mandelbrot engine. It walks a runtime-sized pixel
// grid and iterates each pixel on an external ALU using a start/done pulse
// handshake. Each result is mapped to a saturated OUT_BITS value and streamed
// out on a valid/ready port. Frame configuration is latched when a run starts.
module mandelbrot_frame_sched #(
  parameter int BITWIDTH = 10,
  parameter int CTRWIDTH = 7,
  parameter int XW       = 9,
  parameter int YW       = 8,
  parameter int OUT_BITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          abort,
  output logic                          busy,
  output logic                          finished,
  input  logic [CTRWIDTH-1:0]           max_ctr,
  input  logic [$clog2(CTRWIDTH)-1:0]   ctr_shift,
  input  logic [BITWIDTH-1:0]           cr_offset,
  input  logic [BITWIDTH-1:0]           ci_offset,
  input  logic [BITWIDTH-1:0]           cr_step,
  input  logic [BITWIDTH-1:0]           ci_step,
  input  logic [XW-1:0]                 width_m1,
  input  logic [YW-1:0]                 height_m1,
  output logic                          alu_start,
  input  logic                          alu_done,
  output logic [BITWIDTH-1:0]           alu_cr,
  output logic [BITWIDTH-1:0]           alu_ci,
  output logic [BITWIDTH-1:0]           alu_zr,
  output logic [BITWIDTH-1:0]           alu_zi,
  input  logic [BITWIDTH-1:0]           alu_zr_next,
  input  logic [BITWIDTH-1:0]           alu_zi_next,
  input  logic                          alu_size,
  input  logic                          alu_overflow,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [OUT_BITS-1:0]           pix_val,
  output logic [XW-1:0]                 pix_x,
  output logic [YW-1:0]                 pix_y,
  output logic                          pix_last
);

  localparam int SW = $clog2(CTRWIDTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DRAIN} state_t;

  state_t              state;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [CTRWIDTH-1:0] ctr;

  // Configuration captured at run; inputs may change freely mid-frame.
  logic [CTRWIDTH-1:0] max_ctr_q;
  logic [SW-1:0]       ctr_shift_q;
  logic [BITWIDTH-1:0] cr_offset_q;
  logic [BITWIDTH-1:0] cr_step_q;
  logic [BITWIDTH-1:0] ci_step_q;
  logic [XW-1:0]       width_m1_q;
  logic [YW-1:0]       height_m1_q;

  logic                escape;
  logic                row_end;
  logic                frame_end;
  logic [CTRWIDTH-1:0] shifted;
  logic [OUT_BITS-1:0] mapped;

  // Escape decision, grid position and the saturating counter-to-pixel map.
  assign escape    = alu_size | alu_overflow | (ctr == max_ctr_q);
  assign row_end   = (x == width_m1_q);
  assign frame_end = row_end && (y == height_m1_q);
  assign shifted   = ctr >> ctr_shift_q;
  assign mapped    = ((shifted >> OUT_BITS) != '0) ? '1 : shifted[OUT_BITS-1:0];

  // Frame sequencer: state, operands, coordinates and all port outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is tested inside the clocked block, so it only takes effect
    // on an edge and needs no asynchronous recovery timing.
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      finished    <= 1'b1;
      alu_start   <= 1'b0;
      pix_valid   <= 1'b0;
      pix_val     <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_last    <= 1'b0;
      x           <= '0;
      y           <= '0;
      ctr         <= '0;
      alu_cr      <= '0;
      alu_ci      <= '0;
      alu_zr      <= '0;
      alu_zi      <= '0;
      max_ctr_q   <= '0;
      ctr_shift_q <= '0;
      cr_offset_q <= '0;
      cr_step_q   <= '0;
      ci_step_q   <= '0;
      width_m1_q  <= '0;
      height_m1_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every branch read the pre-edge
      // values of x, y and ctr, whatever order the statements are written in.
      alu_start <= 1'b0;
      unique case (state)
        IDLE: begin
          // abort has priority, so run and abort together do not start a frame.
          if (run && !abort) begin
            max_ctr_q   <= max_ctr;
            ctr_shift_q <= ctr_shift;
            cr_offset_q <= cr_offset;
            cr_step_q   <= cr_step;
            ci_step_q   <= ci_step;
            width_m1_q  <= width_m1;
            height_m1_q <= height_m1;
            alu_cr      <= cr_offset;
            alu_ci      <= ci_offset;
            alu_zr      <= '0;
            alu_zi      <= '0;
            x           <= '0;
            y           <= '0;
            ctr         <= '0;
            alu_start   <= 1'b1;
            busy        <= 1'b1;
            finished    <= 1'b0;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          if (abort) begin
            busy     <= 1'b0;
            finished <= 1'b1;
            state    <= IDLE;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (abort) begin
            // A done pulse in the abort cycle means nothing is left in flight.
            if (alu_done) begin
              busy     <= 1'b0;
              finished <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (alu_done) begin
            if (escape) begin
              pix_val   <= mapped;
              pix_x     <= x;
              pix_y     <= y;
              pix_last  <= frame_end;
              pix_valid <= 1'b1;
              state     <= EMIT;
            end else begin
              alu_zr    <= alu_zr_next;
              alu_zi    <= alu_zi_next;
              ctr       <= ctr + 1'b1;
              alu_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end

        EMIT: begin
          if (abort) begin
            pix_valid <= 1'b0;
            busy      <= 1'b0;
            finished  <= 1'b1;
            state     <= IDLE;
          end else if (pix_ready) begin
            pix_valid <= 1'b0;
            if (pix_last) begin
              busy     <= 1'b0;
              finished <= 1'b1;
              state    <= IDLE;
            end else begin
              alu_zr <= '0;
              alu_zi <= '0;
              ctr    <= '0;
              if (row_end) begin
                x      <= '0;
                y      <= y + 1'b1;
                alu_cr <= cr_offset_q;
                alu_ci <= alu_ci + ci_step_q;
              end else begin
                x      <= x + 1'b1;
                alu_cr <= alu_cr + cr_step_q;
              end
              alu_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end

        DRAIN: begin
          // Swallow the done of the abandoned iteration before reporting idle.
          if (alu_done) begin
            busy     <= 1'b0;
            finished <= 1'b1;
            state    <= IDLE;
          end
        end

        default: begin
          busy     <= 1'b0;
          finished <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_frame_sched.sv
// Self-checking bench for mandelbrot_frame_sched. A behavioural ALU answers
// start pulses. A frame model lists every pixel with its expected value.
// One negedge process checks operands and pixel outputs against that list.
module tb_mandelbrot_frame_sched;
  localparam int BW = 10;
  localparam int CW = 7;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int OB = 4;
  localparam int SW = $clog2(CW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic          busy, finished;
  logic [CW-1:0] max_ctr = '0;
  logic [SW-1:0] ctr_shift = '0;
  logic [BW-1:0] cr_offset = '0, ci_offset = '0, cr_step = '0, ci_step = '0;
  logic [XW-1:0] width_m1 = '0;
  logic [YW-1:0] height_m1 = '0;
  logic          alu_start;
  logic          alu_done = 1'b0;
  logic [BW-1:0] alu_cr, alu_ci, alu_zr, alu_zi;
  logic [BW-1:0] alu_zr_next = '0, alu_zi_next = '0;
  logic          alu_size = 1'b0, alu_overflow = 1'b0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [OB-1:0] pix_val;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_last;

  always #5 clk = ~clk;

  mandelbrot_frame_sched #(
    .BITWIDTH(BW), .CTRWIDTH(CW), .XW(XW), .YW(YW), .OUT_BITS(OB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .abort(abort),
    .busy(busy), .finished(finished),
    .max_ctr(max_ctr), .ctr_shift(ctr_shift),
    .cr_offset(cr_offset), .ci_offset(ci_offset),
    .cr_step(cr_step), .ci_step(ci_step),
    .width_m1(width_m1), .height_m1(height_m1),
    .alu_start(alu_start), .alu_done(alu_done),
    .alu_cr(alu_cr), .alu_ci(alu_ci), .alu_zr(alu_zr), .alu_zi(alu_zi),
    .alu_zr_next(alu_zr_next), .alu_zi_next(alu_zi_next),
    .alu_size(alu_size), .alu_overflow(alu_overflow),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_val(pix_val),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ALU behaviour knobs: esc_mode 0 = operand hash, 1 = size at iteration
  // esc_at, 2 = never; ovf_at >= 0 forces overflow at that iteration.
  int esc_mode = 2, esc_at = 0, ovf_at = -1;
  int lat_min = 1, lat_max = 1;
  int ready_mode = 1;  // 0 random, 1 always, 2 never

  function automatic logic [BW-1:0] f_zr(input logic [BW-1:0] zr, cr);
    return zr + cr + BW'(3);
  endfunction

  function automatic logic [BW-1:0] f_zi(input logic [BW-1:0] zr, zi, ci);
    return zi ^ (ci + zr);
  endfunction

  function automatic logic f_size(input logic [BW-1:0] zr, zi, input int k);
    logic [BW-1:0] h;
    h = zr ^ zi;
    case (esc_mode)
      0:       return h[2:0] == 3'd5;
      1:       return k == esc_at;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic f_ovf(input logic [BW-1:0] zr, zi, input int k);
    if (ovf_at >= 0) return k == ovf_at;
    if (esc_mode == 0) return (zr[BW-1:BW-3] == 3'b111) && zi[0];
    return 1'b0;
  endfunction

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [OB-1:0] val;
    logic          last;
    logic [BW-1:0] cr;
    logic [BW-1:0] ci;
  } pix_t;

  pix_t          exp_q[$];
  pix_t          acc_log[$];
  logic [BW-1:0] start_cr_log[$];
  logic [BW-1:0] start_ci_log[$];

  // Expected pixel list of a whole frame, from the current configuration.
  task automatic build_frame();
    pix_t          p;
    logic [BW-1:0] zr, zi;
    int            k, s;
    exp_q.delete();
    for (int yy = 0; yy <= int'(height_m1); yy++) begin
      for (int xx = 0; xx <= int'(width_m1); xx++) begin
        p.x    = XW'(xx);
        p.y    = YW'(yy);
        p.cr   = BW'(int'(cr_offset) + xx * int'(cr_step));
        p.ci   = BW'(int'(ci_offset) + yy * int'(ci_step));
        p.last = (xx == int'(width_m1)) && (yy == int'(height_m1));
        zr = '0;
        zi = '0;
        k  = 0;
        while (!(f_size(zr, zi, k) || f_ovf(zr, zi, k) || k == int'(max_ctr))) begin
          logic [BW-1:0] nzr;
          nzr = f_zr(zr, p.cr);
          zi  = f_zi(zr, zi, p.ci);
          zr  = nzr;
          k++;
        end
        s     = k >> int'(ctr_shift);
        p.val = (s > (1 << OB) - 1) ? OB'((1 << OB) - 1) : OB'(s);
        exp_q.push_back(p);
      end
    end
  endtask

  // ALU responder, pixel sink and per-cycle compare against the model.
  int            cnt = 0;
  int            k_iter = 0;
  logic [BW-1:0] ez_r = '0, ez_i = '0;

  always @(negedge clk) begin
    pix_t a;
    alu_done     = 1'b0;
    alu_size     = 1'b0;
    alu_overflow = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        alu_done     = 1'b1;
        alu_size     = f_size(alu_zr, alu_zi, k_iter);
        alu_overflow = f_ovf(alu_zr, alu_zi, k_iter);
        alu_zr_next  = f_zr(alu_zr, alu_cr);
        alu_zi_next  = f_zi(alu_zr, alu_zi, alu_ci);
        ez_r         = alu_zr_next;
        ez_i         = alu_zi_next;
        k_iter++;
      end
    end
    if (finished === 1'b1) begin
      k_iter = 0;
      ez_r   = '0;
      ez_i   = '0;
    end
    if (alu_start === 1'b1) begin
      if (exp_q.size() == 0) check("start_without_pixel", 1, 0);
      else begin
        check("alu_cr", alu_cr, exp_q[0].cr);
        check("alu_ci", alu_ci, exp_q[0].ci);
      end
      check("alu_zr", alu_zr, ez_r);
      check("alu_zi", alu_zi, ez_i);
      if (k_iter == 0) begin
        start_cr_log.push_back(alu_cr);
        start_ci_log.push_back(alu_ci);
      end
      cnt = $urandom_range(lat_max, lat_min);
    end
    case (ready_mode)
      0:       pix_ready = ($urandom_range(99) < 70);
      1:       pix_ready = 1'b1;
      default: pix_ready = 1'b0;
    endcase
    if (pix_valid === 1'b1) begin
      check("no_start_in_emit", alu_start, 0);
      if (exp_q.size() == 0) check("unexpected_pixel", 1, 0);
      else begin
        check("pix_x", pix_x, exp_q[0].x);
        check("pix_y", pix_y, exp_q[0].y);
        check("pix_val", pix_val, exp_q[0].val);
        check("pix_last", pix_last, exp_q[0].last);
        if (pix_ready && !abort && rst_n) begin
          a.x = pix_x; a.y = pix_y; a.val = pix_val; a.last = pix_last;
          a.cr = '0;   a.ci = '0;
          acc_log.push_back(a);
          void'(exp_q.pop_front());
          k_iter = 0;
          ez_r   = '0;
          ez_i   = '0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_cfg(input int w, h, mx, sh, cro, cio, crs, cis);
    width_m1  = XW'(w);
    height_m1 = YW'(h);
    max_ctr   = CW'(mx);
    ctr_shift = SW'(sh);
    cr_offset = BW'(cro);
    ci_offset = BW'(cio);
    cr_step   = BW'(crs);
    ci_step   = BW'(cis);
  endtask

  // Build the model, pulse run, then scramble config to prove it was latched.
  task automatic start_frame();
    build_frame();
    acc_log.delete();
    start_cr_log.delete();
    start_ci_log.delete();
    run = 1'b1;
    tick();
    run = 1'b0;
    set_cfg($urandom_range(7), $urandom_range(7), $urandom_range(127), $urandom_range(7),
            $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c = 0;
    while (finished !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    check(name, finished, 1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int c = 0;
    while (pix_valid !== 1'b1 && c < budget) begin
      tick();
      c++;
    end
    check(name, pix_valid, 1);
  endtask

  task automatic finish_frame(input string name);
    wait_idle({name, "_idle"}, 6000);
    check({name, "_all_pixels"}, exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [OB-1:0] v0;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_finished", finished, 1);
    check("rst_busy", busy, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_alu_cr", alu_cr, 0);
    check("rst_pix_val", pix_val, 0);
    rst_n = 1'b1;
    tick();

    // 2x2 frame, ALU done two cycles after start, never escapes before max_ctr
    esc_mode = 2; ovf_at = -1; lat_min = 2; lat_max = 2; ready_mode = 1;
    set_cfg(1, 1, 5, 0, 0, 0, 1, 1);
    start_frame();
    check("t1_busy", busy, 1);
    finish_frame("t1");
    check("t1_count", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t1_x", acc_log[i].x, i % 2);
        check("t1_y", acc_log[i].y, i / 2);
        check("t1_val", acc_log[i].val, 5);
        check("t1_last", acc_log[i].last, (i == 3) ? 1 : 0);
      end
    end
    check("t1_finished", finished, 1);

    // cr wraps across a row; ci advances once per row
    lat_min = 1; lat_max = 1;
    set_cfg(3, 1, 1, 0, -512, 5, 300, 7);
    start_frame();
    finish_frame("t2");
    check("t2_starts", start_cr_log.size(), 8);
    if (start_cr_log.size() == 8) begin
      check("t2_cr0", start_cr_log[0], 10'h200);
      check("t2_cr1", start_cr_log[1], 10'h32C);
      check("t2_cr2", start_cr_log[2], 10'h058);
      check("t2_cr3", start_cr_log[3], 10'h184);
      check("t2_cr4", start_cr_log[4], 10'h200);
      check("t2_ci_row0", start_ci_log[3], 5);
      check("t2_ci_row1", start_ci_log[4], 12);
    end

    // Counter map: escape at 37 with shift 2 gives 9; max 100 saturates to 15
    esc_mode = 1; esc_at = 37;
    set_cfg(0, 0, 100, 2, 0, 0, 0, 0);
    start_frame();
    finish_frame("t3a");
    if (acc_log.size() == 1) begin
      check("t3a_val", acc_log[0].val, 9);
      check("t3a_last", acc_log[0].last, 1);
    end else check("t3a_count", acc_log.size(), 1);
    esc_mode = 2;
    set_cfg(0, 0, 100, 2, 0, 0, 0, 0);
    start_frame();
    finish_frame("t3b");
    if (acc_log.size() == 1) check("t3b_val", acc_log[0].val, 15);
    else check("t3b_count", acc_log.size(), 1);

    // Overflow forces escape
    ovf_at = 3;
    set_cfg(0, 0, 50, 0, 0, 0, 0, 0);
    start_frame();
    finish_frame("t6b");
    if (acc_log.size() == 1) check("t6b_val", acc_log[0].val, 3);
    else check("t6b_count", acc_log.size(), 1);
    ovf_at = -1;

    // Backpressure: pixel held for 10 cycles without new ALU starts
    ready_mode = 2;
    set_cfg(1, 0, 2, 0, 17, 3, 9, 4);
    start_frame();
    wait_valid("t4_valid", 200);
    v0 = pix_val; x0 = pix_x; y0 = pix_y;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_hold_valid", pix_valid, 1);
      check("t4_hold_val", pix_val, v0);
      check("t4_hold_x", pix_x, x0);
      check("t4_hold_y", pix_y, y0);
      check("t4_hold_start", alu_start, 0);
    end
    ready_mode = 1;
    finish_frame("t4");

    // Abort in WAIT drains the in-flight ALU op; run meanwhile is ignored
    lat_min = 4; lat_max = 4;
    set_cfg(1, 0, 10, 0, 0, 0, 1, 1);
    start_frame();
    check("t5_in_issue", alu_start, 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_drain_busy", busy, 1);
    run = 1'b1;
    tick();
    run = 1'b0;
    check("t5_drain_busy2", busy, 1);
    wait_idle("t5_drain_done", 20);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_run_ignored", busy, 0);
    end
    exp_q.delete();
    lat_min = 1; lat_max = 3;
    set_cfg(1, 1, 4, 0, 100, 50, 3, 2);
    start_frame();
    finish_frame("t5_next");
    if (acc_log.size() > 0) begin
      check("t5_next_x0", acc_log[0].x, 0);
      check("t5_next_y0", acc_log[0].y, 0);
    end else check("t5_next_count", acc_log.size(), 4);

    // Reset while a pixel is waiting in EMIT
    ready_mode = 2;
    set_cfg(2, 0, 3, 0, 1, 1, 1, 1);
    start_frame();
    wait_valid("t6_valid", 200);
    rst_n = 1'b0;
    tick();
    check("t6_rst_valid", pix_valid, 0);
    check("t6_rst_finished", finished, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pix_x", pix_x, 0);
    rst_n = 1'b1;
    exp_q.delete();
    ready_mode = 1;
    tick();

    // Randomised frames with hashed escapes, random latency and backpressure
    esc_mode = 0; ovf_at = -1; lat_min = 1; lat_max = 3; ready_mode = 0;
    for (int f = 0; f < 10; f++) begin
      set_cfg($urandom_range(5), $urandom_range(3), $urandom_range(20), $urandom_range(7),
              $urandom, $urandom, $urandom, $urandom);
      start_frame();
      if ($urandom_range(2) == 0) begin
        int wait_cycles;
        wait_cycles = $urandom_range(60, 5);
        for (int i = 0; i < wait_cycles && finished !== 1'b1; i++) tick();
        if (finished !== 1'b1) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
        end
        wait_idle("rand_abort_idle", 40);
        for (int i = 0; i < 6; i++) tick();
        exp_q.delete();
      end else begin
        finish_frame("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
